// File: rtl/mult60_limb_seq.sv
// Limb sequencer for a wide multiply: splits a/b into LIMB_W limbs, streams the
// limb pairs to an external fixed-latency multiplier and shift-accumulates the products.
module mult60_limb_seq #(
  parameter int LIMB_W   = 30,
  parameter int N_LIMBS  = 2,
  parameter int MULT_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_LIMBS*LIMB_W-1:0]     a,
  input  logic [N_LIMBS*LIMB_W-1:0]     b,
  output logic [LIMB_W-1:0]             mul_a,
  output logic [LIMB_W-1:0]             mul_b,
  input  logic [2*LIMB_W-1:0]           mul_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*N_LIMBS*LIMB_W-1:0]   p
);
  localparam int OW = N_LIMBS*LIMB_W;
  localparam int PW = 2*OW;
  localparam int CW = $clog2(N_LIMBS+1);
  localparam int SW = $clog2(2*N_LIMBS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state;
  logic [OW-1:0]            oa, ob;
  logic [PW-1:0]            acc, acc_nxt, term;
  logic [CW-1:0]            i, j, ni, nj;
  logic                     last;
  // Stage 0 tags the pair being issued this cycle; stage MULT_LAT lines up with mul_p.
  logic [MULT_LAT:0]          vld_pipe;
  logic [MULT_LAT:0][SW-1:0]  sh_pipe;

  always_comb begin
    last = (i == CW'(N_LIMBS-1)) && (j == CW'(N_LIMBS-1));
    if (j == CW'(N_LIMBS-1)) begin
      nj = '0;
      ni = i + CW'(1);
    end else begin
      nj = j + CW'(1);
      ni = i;
    end
    term    = PW'(mul_p) << (LIMB_W * sh_pipe[MULT_LAT]);
    acc_nxt = vld_pipe[MULT_LAT] ? acc + term : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      oa        <= '0;
      ob        <= '0;
      i         <= '0;
      j         <= '0;
      vld_pipe  <= '0;
      sh_pipe   <= '0;
    end else begin
      vld_pipe[MULT_LAT:1] <= vld_pipe[MULT_LAT-1:0];
      sh_pipe[MULT_LAT:1]  <= sh_pipe[MULT_LAT-1:0];
      vld_pipe[0] <= 1'b0;
      sh_pipe[0]  <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      acc         <= acc_nxt;
      case (state)
        IDLE: if (in_valid) begin
          oa          <= a;
          ob          <= b;
          acc         <= '0;
          i           <= '0;
          j           <= '0;
          mul_a       <= a[LIMB_W-1:0];
          mul_b       <= b[LIMB_W-1:0];
          vld_pipe[0] <= 1'b1;
          in_ready    <= 1'b0;
          state       <= ISSUE;
        end
        ISSUE: if (last) begin
          state <= DRAIN;
        end else begin
          i           <= ni;
          j           <= nj;
          mul_a       <= oa[ni*LIMB_W +: LIMB_W];
          mul_b       <= ob[nj*LIMB_W +: LIMB_W];
          vld_pipe[0] <= 1'b1;
          sh_pipe[0]  <= SW'(ni) + SW'(nj);
        end
        // Stage 0 is empty here, so this fires on the edge absorbing the final product.
        DRAIN: if (vld_pipe[MULT_LAT] && (vld_pipe[MULT_LAT-1:0] == '0)) begin
          p         <= acc_nxt;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult60_limb_seq.sv
// Directed bench for mult60_limb_seq with a one-cycle 30x30 multiplier model.
module tb_mult60_limb_seq;
  logic         clk = 0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [59:0]  a, b;
  logic [29:0]  mul_a, mul_b;
  logic [59:0]  mul_p;
  logic [119:0] p;

  int n_run = 0, n_fail = 0;

  typedef struct {
    logic [59:0]  a;
    logic [59:0]  b;
    logic [119:0] p;
  } vec_t;
  vec_t vecs[8];

  logic [29:0] ia[5], ib[5];

  mult60_limb_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mul_p <= mul_a * mul_b;

  task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE at #1 after an edge; returns result and accept-to-out_valid latency.
  task automatic run_op(input logic [59:0] va, input logic [59:0] vb, input bit hs,
                        output logic [119:0] res, output int lat);
    int cyc;
    in_valid = 1; a = va; b = vb;
    chk("ready_before_accept", 120'(in_ready), 120'(1));
    step();
    in_valid = 0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (cyc < 5) begin ia[cyc] = mul_a; ib[cyc] = mul_b; end
      step();
      cyc++;
    end
    res = p;
    lat = cyc;
    if (hs) begin
      out_ready = 1;
      step();
      chk("valid_drop", 120'(out_valid), 120'(0));
      chk("p_hold", p, res);
    end
  endtask

  initial begin
    logic [119:0] res;
    int lat, k, r, acc_e[4];
    logic pre_ir, pre_ov;
    logic [119:0] pre_p;

    vecs[0] = '{60'd1, 60'd1, 120'd1};
    vecs[1] = '{60'hFFFFFFFFFFFFFFF, 60'hFFFFFFFFFFFFFFF, 120'hFFFFFFFFFFFFFFE000000000000001};
    vecs[2] = '{60'd1 << 30, 60'd1 << 30, 120'd1 << 60};
    vecs[3] = '{(60'd1 << 30) + 60'd3, 60'd5, (120'd5 << 30) + 120'd15};
    vecs[4] = '{60'd3, 60'd5, 120'd15};
    vecs[5] = '{60'd0, 60'hABCDEF012345678, 120'd0};
    vecs[6] = '{60'hFFFFFFFFFFFFFFF, 60'd1, 120'hFFFFFFFFFFFFFFF};
    vecs[7] = '{60'd1 << 59, 60'd1 << 59, 120'd1 << 118};

    rst = 1; in_valid = 1; a = 60'd7; b = 60'd7; out_ready = 1;
    step(); step();
    rst = 0; in_valid = 0;
    chk("rst_in_ready", 120'(in_ready), 120'(1));
    chk("rst_out_valid", 120'(out_valid), 120'(0));
    chk("rst_p", p, 120'(0));
    chk("rst_mul_a", 120'(mul_a), 120'(0));
    chk("rst_mul_b", 120'(mul_b), 120'(0));

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].a, vecs[v].b, 1, res, lat);
      chk($sformatf("vec%0d_p", v), res, vecs[v].p);
      chk($sformatf("vec%0d_lat", v), 120'(lat), 120'(5));
      if (v == 0) begin
        chk("iss0", {60'(ia[0]), 60'(ib[0])}, {60'd1, 60'd1});
        chk("iss1", {60'(ia[1]), 60'(ib[1])}, {60'd1, 60'd0});
        chk("iss2", {60'(ia[2]), 60'(ib[2])}, {60'd0, 60'd1});
        chk("iss3", {60'(ia[3]), 60'(ib[3])}, {60'd0, 60'd0});
        chk("drain_mul_a", 120'(ia[4]), 120'(0));
      end
      if (v == 2) begin
        chk("pow_iss0_b", 120'(ib[0]), 120'(0));
        chk("pow_iss3", {60'(ia[3]), 60'(ib[3])}, {60'd1, 60'd1});
      end
    end

    // Backpressure in DONE with a competing request on the input.
    out_ready = 0;
    run_op(60'd7, 60'd9, 0, res, lat);
    chk("bp_p", res, 120'd63);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; a = 60'd11 + 60'(c); b = 60'd13;
      step();
      chk("bp_valid_held", 120'(out_valid), 120'(1));
      chk("bp_p_held", p, 120'd63);
      chk("bp_no_ready", 120'(in_ready), 120'(0));
    end
    out_ready = 1;
    step();
    in_valid = 0;
    chk("bp_release_valid", 120'(out_valid), 120'(0));
    chk("bp_release_ready", 120'(in_ready), 120'(1));
    chk("bp_release_p", p, 120'd63);
    step();
    chk("bp_no_accept", 120'(in_ready), 120'(1));

    // Reset in the third issue cycle.
    in_valid = 1; a = 60'd1; b = 60'd1;
    step();
    in_valid = 0;
    step(); step();
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_in_ready", 120'(in_ready), 120'(1));
    chk("mid_rst_out_valid", 120'(out_valid), 120'(0));
    chk("mid_rst_p", p, 120'(0));
    chk("mid_rst_mul", {60'(mul_a), 60'(mul_b)}, 120'(0));
    run_op(60'd3, 60'd5, 1, res, lat);
    chk("post_rst_p", res, 120'd15);
    chk("post_rst_lat", 120'(lat), 120'(5));

    // Back-to-back throughput with in_valid held high.
    k = 0; r = 0;
    in_valid = 1; a = vecs[0].a; b = vecs[0].b; out_ready = 1;
    for (int cyc = 0; cyc < 60 && !(k == 4 && r == 4); cyc++) begin
      pre_ir = in_ready; pre_ov = out_valid; pre_p = p;
      if (pre_ov) begin
        if (r < 4) chk($sformatf("tp_res%0d", r), pre_p, vecs[r == 3 ? 4 : r].p);
        r++;
      end
      step();
      if (pre_ir && in_valid) begin
        acc_e[k] = cyc;
        k++;
        if (k < 4) begin
          a = vecs[k == 3 ? 4 : k].a; b = vecs[k == 3 ? 4 : k].b;
        end else in_valid = 0;
      end
    end
    in_valid = 0;
    chk("tp_accepts", 120'(k), 120'(4));
    chk("tp_results", 120'(r), 120'(4));
    for (int x = 1; x < 4; x++)
      if (x < k) chk($sformatf("tp_gap%0d", x), 120'(acc_e[x] - acc_e[x-1]), 120'(7));
    step(); step();
    chk("tp_no_extra_valid", 120'(out_valid), 120'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
